conv_mem_arbiter: RTL

- Shares the single layer-memory port (cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd) between two requesters:
  - R0: the convolution/pooling engine (mostly writes, high priority).
  - R1: a readback/flatten engine (reads and writes).
- Sits between the engines and the testbench-facing memory port.
- Fixed priority to R0 with a starvation guard, registered memory strobes, and read-data return routing.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_mem_arbiter_if.sv | 36 +++
 rtl/conv_rd_tag_pipe.sv | 66 ++++++
 rtl/conv_mem_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and encodings for the convolution layer-memory arbiter.
package conv_pkg;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 20;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_L0_K0 = 3'd1,
    SEL_L0_K1 = 3'd2,
    SEL_L1_K0 = 3'd3,
    SEL_L1_K1 = 3'd4,
    SEL_L2    = 3'd5
  } csel_e;

  localparam int unsigned REQ_R0 = 0;
  localparam int unsigned REQ_R1 = 1;

endpackage

// File: rtl/conv_mem_arbiter_if.sv
// Requester handshakes plus the shared layer-memory port seen by the arbiter.
interface conv_mem_arbiter_if #(
  parameter int unsigned AW = conv_pkg::AW,
  parameter int unsigned DW = conv_pkg::DW
);
  logic          r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [2:0]    r0_sel;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;

  logic          r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [2:0]    r1_sel;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;

  logic          cwr, crd, err_sel;
  logic [2:0]    csel;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr, cdata_rd;

  modport slave (
    input  r0_req, r0_we, r0_sel, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_sel, r1_addr, r1_wdata,
    input  cdata_rd,
    output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
    output cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, err_sel
  );

  modport master (
    output r0_req, r0_we, r0_sel, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_sel, r1_addr, r1_wdata,
    output cdata_rd,
    input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
    input  cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, err_sel
  );
endinterface

// File: rtl/conv_rd_tag_pipe.sv
// Read-return pipeline: carries the requester tag alongside each read strobe and
// steers cdata_rd into the owning requester's rdata when the tag emerges.
module conv_rd_tag_pipe #(
  parameter int unsigned DW     = conv_pkg::DW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          issue_i,
  input  logic          tag_i,
  input  logic          zero_i,
  input  logic [DW-1:0] cdata_rd_i,
  output logic [1:0]    rvalid_o,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o
);
  import conv_pkg::*;

  logic [RD_LAT-1:0] vld_q, vld_d, tag_q, tag_d, zero_q, zero_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d, cap;

  always_comb begin
    vld_d     = '0;
    tag_d     = '0;
    zero_d    = '0;
    vld_d[0]  = issue_i;
    tag_d[0]  = tag_i;
    zero_d[0] = zero_i;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i]  = vld_q[i-1];
      tag_d[i]  = tag_q[i-1];
      zero_d[i] = zero_q[i-1];
    end
    // Reads to SEL_NONE never reached memory; return zero instead of the bus value.
    cap              = zero_q[RD_LAT-1] ? '0 : cdata_rd_i;
    rvalid_d         = '0;
    rvalid_d[REQ_R0] = vld_q[RD_LAT-1] && !tag_q[RD_LAT-1];
    rvalid_d[REQ_R1] = vld_q[RD_LAT-1] && tag_q[RD_LAT-1];
    rdata0_d         = rvalid_d[REQ_R0] ? cap : rdata0_q;
    rdata1_d         = rvalid_d[REQ_R1] ? cap : rdata1_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      tag_q    <= '0;
      zero_q   <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      zero_q   <= zero_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: rtl/conv_mem_arbiter.sv
// Fixed-priority (R0) arbiter with starvation guard for the shared layer-memory
// port; memory strobes are registered one cycle after acceptance.
module conv_mem_arbiter #(
  parameter int unsigned AW         = conv_pkg::AW,
  parameter int unsigned DW         = conv_pkg::DW,
  parameter int unsigned MAX_CONSEC = 4,
  parameter int unsigned RD_LAT     = 1
) (
  input logic               clk,
  input logic               reset,
  conv_mem_arbiter_if.slave bus
);
  import conv_pkg::*;

  localparam int unsigned StrW      = 4;
  localparam logic [StrW-1:0] StreakMax = StrW'(MAX_CONSEC);

  logic            gnt0, gnt1, acc, acc_we, is_none, rd_issue;
  logic [2:0]      acc_sel;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_wdata;
  logic [1:0]      rvalid;

  logic [StrW-1:0] streak_q, streak_d;
  logic            cwr_q, cwr_d, crd_q, crd_d, err_sel_q, err_sel_d;
  logic [2:0]      csel_q, csel_d;
  logic [AW-1:0]   caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DW-1:0]   cdata_wr_q, cdata_wr_d;

  always_comb begin
    gnt1      = bus.r1_req && (!bus.r0_req || streak_q == StreakMax);
    gnt0      = bus.r0_req && !gnt1;
    acc       = gnt0 || gnt1;
    acc_we    = gnt1 ? bus.r1_we    : bus.r0_we;
    acc_sel   = gnt1 ? bus.r1_sel   : bus.r0_sel;
    acc_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
    acc_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;
    is_none   = acc_sel == 3'(SEL_NONE);
    rd_issue  = acc && !acc_we;
  end

  always_comb begin
    streak_d = streak_q;
    if (!bus.r1_req || gnt1) begin
      streak_d = '0;
    end else if (gnt0 && streak_q != StreakMax) begin
      streak_d = streak_q + 1'b1;
    end

    cwr_d      = acc && acc_we && !is_none;
    crd_d      = acc && !acc_we && !is_none;
    csel_d     = csel_q;
    caddr_wr_d = caddr_wr_q;
    caddr_rd_d = caddr_rd_q;
    cdata_wr_d = cdata_wr_q;
    // Address/data fields only move when a real strobe goes out.
    if (cwr_d || crd_d) csel_d = acc_sel;
    if (cwr_d) begin
      caddr_wr_d = acc_addr;
      cdata_wr_d = acc_wdata;
    end
    if (crd_d) caddr_rd_d = acc_addr;
    err_sel_d = err_sel_q || (acc && is_none);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q   <= '0;
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      csel_q     <= '0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      err_sel_q  <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      cwr_q      <= cwr_d;
      crd_q      <= crd_d;
      csel_q     <= csel_d;
      caddr_wr_q <= caddr_wr_d;
      caddr_rd_q <= caddr_rd_d;
      cdata_wr_q <= cdata_wr_d;
      err_sel_q  <= err_sel_d;
    end
  end

  conv_rd_tag_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk_i      (clk),
    .rst_i      (reset),
    .issue_i    (rd_issue),
    .tag_i      (gnt1),
    .zero_i     (is_none),
    .cdata_rd_i (bus.cdata_rd),
    .rvalid_o   (rvalid),
    .rdata0_o   (bus.r0_rdata),
    .rdata1_o   (bus.r1_rdata)
  );

  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = rvalid[REQ_R0];
  assign bus.r1_rvalid = rvalid[REQ_R1];
  assign bus.cwr       = cwr_q;
  assign bus.crd       = crd_q;
  assign bus.csel      = csel_q;
  assign bus.caddr_wr  = caddr_wr_q;
  assign bus.caddr_rd  = caddr_rd_q;
  assign bus.cdata_wr  = cdata_wr_q;
  assign bus.err_sel   = err_sel_q;

endmodule
